// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between the WB stage and a long-latency unit.
// The pipeline WB stage always wins the port. LLU results wait in a small FIFO and are written
// in slots where WB is idle. A busy scoreboard tracks registers that still have an LLU result
// outstanding, and a starvation counter asks the pipeline to stall when the FIFO head waits too long.
// Ports:
//   clk, rst_n                   clock; synchronous active-low reset
//   i_wb_valid/i_wb_rd/i_wb_data pipeline WB write request
//   i_llu_issue_valid/_rd        LLU dispatch; o_llu_issue_ready = destination not busy
//   i_llu_res_valid/_rd/_data    LLU result; o_llu_res_ready = FIFO not full
//   i_dec_rs1/rs2/rd             decode indices; o_dec_*_busy = register pending in LLU
//   o_stall_req                  registered; the FIFO head has been starved
//   o_rf_we/o_rf_wr/o_rf_wd      register file write port
module rf_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    input  logic        i_llu_issue_valid,
    input  logic [4:0]  i_llu_issue_rd,
    output logic        o_llu_issue_ready,
    input  logic        i_llu_res_valid,
    input  logic [4:0]  i_llu_res_rd,
    input  logic [31:0] i_llu_res_data,
    output logic        o_llu_res_ready,
    input  logic [4:0]  i_dec_rs1,
    input  logic [4:0]  i_dec_rs2,
    input  logic [4:0]  i_dec_rd,
    output logic        o_dec_rs1_busy,
    output logic        o_dec_rs2_busy,
    output logic        o_dec_rd_busy,
    output logic        o_stall_req,
    output logic        o_rf_we,
    output logic [4:0]  o_rf_wr,
    output logic [31:0] o_rf_wd
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]    r_fifo_rd   [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic [31:0]   r_busy;
    logic          r_stall;

    logic          w_empty;
    logic          w_full;
    logic [4:0]    w_head_rd;
    logic          w_wb_grant;
    logic          w_head_grant;
    logic          w_push;
    logic          w_issue;
    logic          w_starved;
    logic [31:0]   w_busy_nxt;

    assign w_empty      = r_count == '0;
    assign w_full       = r_count == CW'(DEPTH);
    assign w_head_rd    = r_fifo_rd[r_rptr];
    // Writes to x0 are not real writes, so such a WB slot is free for the FIFO head.
    assign w_wb_grant   = rst_n && i_wb_valid && (i_wb_rd != 5'd0);
    assign w_head_grant = rst_n && !w_wb_grant && !w_empty;
    assign w_starved    = r_starve == SW'(STARVE_MAX);

    assign o_rf_we = w_wb_grant || w_head_grant;
    assign o_rf_wr = w_wb_grant ? i_wb_rd : w_head_rd;
    assign o_rf_wd = w_wb_grant ? i_wb_data : r_fifo_data[r_rptr];

    // Ready depends only on occupancy, so a full FIFO refuses a result even while it pops.
    assign o_llu_res_ready   = rst_n && !w_full;
    assign w_push            = i_llu_res_valid && o_llu_res_ready && (i_llu_res_rd != 5'd0);
    assign o_llu_issue_ready = rst_n && ((i_llu_issue_rd == 5'd0) || !r_busy[i_llu_issue_rd]);
    assign w_issue           = i_llu_issue_valid && o_llu_issue_ready && (i_llu_issue_rd != 5'd0);

    // A register being set is never busy, so set and clear of one register never collide.
    assign w_busy_nxt = (r_busy & ~(32'(w_head_grant) << w_head_rd)) | (32'(w_issue) << i_llu_issue_rd);

    // Bit 0 is never set, so x0 reads as not busy without extra gating.
    assign o_dec_rs1_busy = r_busy[i_dec_rs1];
    assign o_dec_rs2_busy = r_busy[i_dec_rs2];
    assign o_dec_rd_busy  = r_busy[i_dec_rd];
    assign o_stall_req    = r_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy   <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_busy   <= w_busy_nxt;
            r_wptr   <= w_push ? r_wptr + 1'b1 : r_wptr;
            r_rptr   <= w_head_grant ? r_rptr + 1'b1 : r_rptr;
            r_count  <= r_count + CW'(w_push) - CW'(w_head_grant);
            r_starve <= (w_empty || w_head_grant) ? '0 : w_starved ? r_starve : r_starve + 1'b1;
            // The counter saturates until the head is granted, so this holds the stall until then.
            r_stall  <= w_starved && !w_head_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= i_llu_res_rd;
            r_fifo_data[r_wptr] <= i_llu_res_data;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter (DEPTH=2, STARVE_MAX=4).
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_wb_valid;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_data;
    logic        i_llu_issue_valid;
    logic [4:0]  i_llu_issue_rd;
    logic        o_llu_issue_ready;
    logic        i_llu_res_valid;
    logic [4:0]  i_llu_res_rd;
    logic [31:0] i_llu_res_data;
    logic        o_llu_res_ready;
    logic [4:0]  i_dec_rs1;
    logic [4:0]  i_dec_rs2;
    logic [4:0]  i_dec_rd;
    logic        o_dec_rs1_busy;
    logic        o_dec_rs2_busy;
    logic        o_dec_rd_busy;
    logic        o_stall_req;
    logic        o_rf_we;
    logic [4:0]  o_rf_wr;
    logic [31:0] o_rf_wd;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    logic [31:0] r_rnd;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .i_llu_issue_valid(i_llu_issue_valid), .i_llu_issue_rd(i_llu_issue_rd),
        .o_llu_issue_ready(o_llu_issue_ready),
        .i_llu_res_valid(i_llu_res_valid), .i_llu_res_rd(i_llu_res_rd),
        .i_llu_res_data(i_llu_res_data), .o_llu_res_ready(o_llu_res_ready),
        .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2), .i_dec_rd(i_dec_rd),
        .o_dec_rs1_busy(o_dec_rs1_busy), .o_dec_rs2_busy(o_dec_rs2_busy),
        .o_dec_rd_busy(o_dec_rd_busy), .o_stall_req(o_stall_req),
        .o_rf_we(o_rf_we), .o_rf_wr(o_rf_wr), .o_rf_wd(o_rf_wd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_wb_valid = 0; i_wb_rd = 0; i_wb_data = 0;
        i_llu_issue_valid = 0; i_llu_issue_rd = 0;
        i_llu_res_valid = 0; i_llu_res_rd = 0; i_llu_res_data = 0;
        i_dec_rs1 = 0; i_dec_rs2 = 0; i_dec_rd = 0;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        i_wb_valid = v; i_wb_rd = rd; i_wb_data = d;
    endtask

    task automatic res(input logic v, input logic [4:0] rd, input logic [31:0] d);
        i_llu_res_valid = v; i_llu_res_rd = rd; i_llu_res_data = d;
    endtask

    task automatic wr(input string tag, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, "_we"}, o_rf_we, 1);
        chk({tag, "_wr"}, o_rf_wr, rd);
        chk({tag, "_wd"}, o_rf_wd, d);
    endtask

    initial begin
        idle();
        rst_n = 0;
        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            tick();
            r_rnd = $urandom;
            i_wb_valid = r_rnd[0]; i_wb_rd = r_rnd[5:1];
            i_llu_issue_valid = r_rnd[6]; i_llu_issue_rd = r_rnd[11:7];
            i_llu_res_valid = r_rnd[12]; i_llu_res_rd = r_rnd[17:13];
            i_dec_rs1 = r_rnd[22:18]; i_dec_rs2 = r_rnd[27:23]; i_dec_rd = {r_rnd[31:28], r_rnd[0]};
            i_wb_data = $urandom; i_llu_res_data = $urandom;
            #1;
            chk("rst_we", o_rf_we, 0);
            chk("rst_res_ready", o_llu_res_ready, 0);
            chk("rst_issue_ready", o_llu_issue_ready, 0);
            chk("rst_stall", o_stall_req, 0);
            chk("rst_busy", {o_dec_rs1_busy, o_dec_rs2_busy, o_dec_rd_busy}, 0);
        end
        idle();
        rst_n = 1;
        tick();
        // Priority: WB first, FIFO head in the next idle slot
        res(1, 7, 32'hBB);
        #1;
        chk("prio_push_ready", o_llu_res_ready, 1);
        chk("prio_push_we", o_rf_we, 0);
        tick();
        res(0, 0, 0);
        wb(1, 5, 32'hAA);
        #1;
        wr("prio_c0", 5, 32'hAA);
        tick();
        wb(0, 0, 0);
        #1;
        wr("prio_c1", 7, 32'hBB);
        tick();
        chk("prio_empty_we", o_rf_we, 0);
        // Scoreboard
        i_llu_issue_valid = 1; i_llu_issue_rd = 9;
        #1;
        chk("sb_issue_ready", o_llu_issue_ready, 1);
        tick();
        i_dec_rs1 = 9; i_dec_rs2 = 9; i_dec_rd = 9;
        #1;
        chk("sb_busy", {o_dec_rs1_busy, o_dec_rs2_busy, o_dec_rd_busy}, 3'b111);
        chk("sb_reissue_ready", o_llu_issue_ready, 0);
        i_llu_issue_rd = 10;
        #1;
        chk("sb_other_ready", o_llu_issue_ready, 1);
        i_llu_issue_valid = 0;
        i_dec_rs2 = 10;
        res(1, 9, 32'h99);
        #1;
        chk("sb_rs2_free", o_dec_rs2_busy, 0);
        tick();
        res(0, 0, 0);
        #1;
        wr("sb_write", 9, 32'h99);
        chk("sb_busy_during_write", o_dec_rs1_busy, 1);
        tick();
        chk("sb_busy_cleared", o_dec_rs1_busy, 0);
        idle();
        // x0 handling
        wb(1, 0, 32'h1234);
        res(1, 0, 32'h5678);
        i_llu_issue_valid = 1; i_llu_issue_rd = 0;
        #1;
        chk("x0_we", o_rf_we, 0);
        chk("x0_res_ready", o_llu_res_ready, 1);
        chk("x0_issue_ready", o_llu_issue_ready, 1);
        tick();
        chk("x0_issue_ready2", o_llu_issue_ready, 1);
        chk("x0_we_after", o_rf_we, 0);
        chk("x0_rs1_busy", o_dec_rs1_busy, 0);
        idle();
        #1;
        chk("x0_fifo_empty", o_rf_we, 0);
        // Full FIFO, WB busy
        wb(1, 1, 32'h11);
        res(1, 12, 32'hC1);
        #1;
        chk("full_ready0", o_llu_res_ready, 1);
        tick();
        res(1, 13, 32'hC2);
        #1;
        chk("full_ready1", o_llu_res_ready, 1);
        wr("full_wb_owns", 1, 32'h11);
        tick();
        res(1, 14, 32'hC3);
        #1;
        chk("full_ready2", o_llu_res_ready, 0);
        tick();
        wb(1, 0, 32'h0);
        #1;
        wr("full_drain0", 12, 32'hC1);
        chk("full_no_push_on_pop", o_llu_res_ready, 0);
        tick();
        res(0, 0, 0);
        wb(0, 0, 0);
        #1;
        wr("full_drain1", 13, 32'hC2);
        tick();
        chk("full_empty", o_rf_we, 0);
        chk("full_no_stall", o_stall_req, 0);
        // Streaming push/pop with pointer wrap
        res(1, 16, 32'd100);
        #1;
        chk("stream_first_we", o_rf_we, 0);
        tick();
        for (int i = 1; i <= 10; i++) begin
            res(1, 5'(16 + i), 32'(100 + i));
            #1;
            chk("stream_ready", o_llu_res_ready, 1);
            wr("stream", 5'(15 + i), 32'(99 + i));
            tick();
        end
        res(0, 0, 0);
        #1;
        wr("stream_last", 26, 32'd110);
        tick();
        chk("stream_empty", o_rf_we, 0);
        // Starvation
        wb(1, 3, 32'h33);
        res(1, 20, 32'hDD);
        tick();
        res(0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("starve_low", o_stall_req, 0);
            tick();
        end
        chk("starve_high", o_stall_req, 1);
        chk("starve_wb_owns", o_rf_wr, 3);
        tick();
        chk("starve_sat", o_stall_req, 1);
        wb(0, 0, 0);
        #1;
        wr("starve_head", 20, 32'hDD);
        chk("starve_still_high", o_stall_req, 1);
        tick();
        chk("starve_released", o_stall_req, 0);
        chk("starve_empty", o_rf_we, 0);
        // Reset mid-operation drops the FIFO and clears busy
        res(1, 21, 32'hEE);
        i_llu_issue_valid = 1; i_llu_issue_rd = 22;
        tick();
        idle();
        i_dec_rs1 = 22;
        #1;
        chk("midrst_busy_set", o_dec_rs1_busy, 1);
        chk("midrst_head_pending", o_rf_wr, 21);
        rst_n = 0;
        #1;
        chk("midrst_we_in_reset", o_rf_we, 0);
        chk("midrst_ready_in_reset", o_llu_res_ready, 0);
        tick();
        rst_n = 1;
        #1;
        chk("midrst_we_after", o_rf_we, 0);
        chk("midrst_busy_after", o_dec_rs1_busy, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
